// File: rtl/stopwatch_counter_gen.sv
// stopwatch_counter_gen
// Minutes/seconds timekeeping core sitting between the tick prescaler and
// the 7-segment formatter. Tick strobes act as clock enables; everything
// runs on the single system clock.
// Optional lap capture is compiled in when LAP_CAPTURE_EN is defined;
// otherwise the lap outputs are tied to zero and lap_req is ignored.

module stopwatch_counter_gen #(
   parameter int MIN_W   = 6,
   parameter int SEC_W   = 6,
   parameter int MIN_MAX = 59,
   parameter int SEC_MAX = 59
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_run,
   input  logic             tick_adj,
   input  logic [1:0]       mode,
   input  logic             count_down,
   input  logic             clear,
   input  logic             lap_req,
   output logic [MIN_W-1:0] mins,
   output logic [SEC_W-1:0] secs,
   output logic             rollover,
   output logic             done,
   output logic             lap_valid,
   output logic [MIN_W-1:0] lap_mins,
   output logic [SEC_W-1:0] lap_secs
);

   localparam logic [0:0] ST_COUNT = 1'b0;
   localparam logic [0:0] ST_DONE  = 1'b1;

   localparam logic [1:0] MODE_RUN     = 2'b00;
   localparam logic [1:0] MODE_ADJ_MIN = 2'b01;
   localparam logic [1:0] MODE_ADJ_SEC = 2'b10;

   localparam logic [MIN_W-1:0] MIN_TOP  = MIN_W'(MIN_MAX);
   localparam logic [MIN_W-1:0] MIN_ONE  = MIN_W'(1);
   localparam logic [MIN_W-1:0] MIN_ZERO = '0;
   localparam logic [SEC_W-1:0] SEC_TOP  = SEC_W'(SEC_MAX);
   localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);
   localparam logic [SEC_W-1:0] SEC_ZERO = '0;

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic [MIN_W-1:0] mins_nxt;
   logic [SEC_W-1:0] secs_nxt;
   logic             roll_nxt;
   logic             active_tick;

   // Run and pause follow the slow strobe, the adjust modes the fast one.
   always_comb begin
      active_tick = 1'b0;
      if (mode == MODE_ADJ_MIN || mode == MODE_ADJ_SEC)
         active_tick = tick_adj;
      else
         active_tick = tick_run;
   end

   // Next value of the counters and FSM for an active strobe; holds otherwise.
   always_comb begin
      mins_nxt  = mins;
      secs_nxt  = secs;
      state_nxt = state;
      roll_nxt  = 1'b0;
      if (active_tick) begin
         case (mode)
            MODE_RUN: begin
               if (state == ST_COUNT) begin
                  if (!count_down) begin
                     if (secs != SEC_TOP) begin
                        secs_nxt = secs + SEC_ONE;
                     end else if (mins != MIN_TOP) begin
                        secs_nxt = SEC_ZERO;
                        mins_nxt = mins + MIN_ONE;
                     end else begin
                        secs_nxt = SEC_ZERO;
                        mins_nxt = MIN_ZERO;
                        roll_nxt = 1'b1;
                     end
                  end else begin
                     if (secs != SEC_ZERO) begin
                        secs_nxt = secs - SEC_ONE;
                        if (mins == MIN_ZERO && secs == SEC_ONE)
                           state_nxt = ST_DONE;
                     end else if (mins != MIN_ZERO) begin
                        secs_nxt = SEC_TOP;
                        mins_nxt = mins - MIN_ONE;
                     end else begin
                        state_nxt = ST_DONE;
                     end
                  end
               end
            end
            MODE_ADJ_MIN: begin
               if (count_down)
                  mins_nxt = (mins == MIN_ZERO) ? MIN_TOP : mins - MIN_ONE;
               else
                  mins_nxt = (mins == MIN_TOP) ? MIN_ZERO : mins + MIN_ONE;
               state_nxt = ST_COUNT;
            end
            MODE_ADJ_SEC: begin
               if (count_down)
                  secs_nxt = (secs == SEC_ZERO) ? SEC_TOP : secs - SEC_ONE;
               else
                  secs_nxt = (secs == SEC_TOP) ? SEC_ZERO : secs + SEC_ONE;
               state_nxt = ST_COUNT;
            end
            default: begin
               mins_nxt = mins;
            end
         endcase
      end
   end

   // Counter and FSM registers; clear beats any tick in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mins     <= MIN_ZERO;
         secs     <= SEC_ZERO;
         rollover <= 1'b0;
         state    <= ST_COUNT;
      end else if (clear) begin
         mins     <= MIN_ZERO;
         secs     <= SEC_ZERO;
         rollover <= 1'b0;
         state    <= ST_COUNT;
      end else begin
         mins     <= mins_nxt;
         secs     <= secs_nxt;
         rollover <= roll_nxt;
         state    <= state_nxt;
      end
   end

   assign done = (state == ST_DONE);

`ifdef LAP_CAPTURE_EN
   // Lap capture grabs the value as it was before this cycle's tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lap_valid <= 1'b0;
         lap_mins  <= MIN_ZERO;
         lap_secs  <= SEC_ZERO;
      end else if (!clear && lap_req) begin
         lap_valid <= 1'b1;
         lap_mins  <= mins;
         lap_secs  <= secs;
      end
   end
`else
   logic unused_lap_req;
   assign unused_lap_req = lap_req;
   assign lap_valid      = 1'b0;
   assign lap_mins       = MIN_ZERO;
   assign lap_secs       = SEC_ZERO;
`endif

endmodule

// File: tb/tb_stopwatch_counter_gen.sv
// tb_stopwatch_counter_gen
// Directed bench for stopwatch_counter_gen. The driver pushes the expected
// post-edge state into a queue; a monitor pops and compares after each edge.
// Lap expectations follow LAP_CAPTURE_EN the same way the design does.

module tb_stopwatch_counter_gen;

   logic       clk;
   logic       rst;
   logic       tick_run;
   logic       tick_adj;
   logic [1:0] mode;
   logic       count_down;
   logic       clear;
   logic       lap_req;
   logic [5:0] mins;
   logic [5:0] secs;
   logic       rollover;
   logic       done;
   logic       lap_valid;
   logic [5:0] lap_mins;
   logic [5:0] lap_secs;

   typedef struct packed {
      logic [5:0] m;
      logic [5:0] s;
      logic       r;
      logic       d;
      logic       lv;
      logic [5:0] lm;
      logic [5:0] ls;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_fails  = 0;

   logic       exp_lap_v = 1'b0;
   logic [5:0] exp_lap_m = 6'd0;
   logic [5:0] exp_lap_s = 6'd0;

   stopwatch_counter_gen #(
      .MIN_W(6), .SEC_W(6), .MIN_MAX(59), .SEC_MAX(59)
   ) dut (
      .clk(clk), .rst(rst), .tick_run(tick_run), .tick_adj(tick_adj),
      .mode(mode), .count_down(count_down), .clear(clear), .lap_req(lap_req),
      .mins(mins), .secs(secs), .rollover(rollover), .done(done),
      .lap_valid(lap_valid), .lap_mins(lap_mins), .lap_secs(lap_secs)
   );

   // 10 ns system clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkField(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic checkOutput(input exp_t e, input string tag);
      checkField({tag, ".mins"},      int'(mins),      int'(e.m));
      checkField({tag, ".secs"},      int'(secs),      int'(e.s));
      checkField({tag, ".rollover"},  int'(rollover),  int'(e.r));
      checkField({tag, ".done"},      int'(done),      int'(e.d));
      checkField({tag, ".lap_valid"}, int'(lap_valid), int'(e.lv));
      checkField({tag, ".lap_mins"},  int'(lap_mins),  int'(e.lm));
      checkField({tag, ".lap_secs"},  int'(lap_secs),  int'(e.ls));
   endtask

   // Drive one cycle of inputs on the falling edge and queue the expected result.
   task automatic applyStimulus(input logic tr, input logic ta, input logic [1:0] md,
                                input logic cd, input logic clr, input logic lr,
                                input int em, input int es, input logic er, input logic ed);
      exp_t e;
      @(negedge clk);
      tick_run   = tr;
      tick_adj   = ta;
      mode       = md;
      count_down = cd;
      clear      = clr;
      lap_req    = lr;
      e.m  = 6'(em);
      e.s  = 6'(es);
      e.r  = er;
      e.d  = ed;
      e.lv = exp_lap_v;
      e.lm = exp_lap_m;
      e.ls = exp_lap_s;
      sb.push_back(e);
   endtask

   // Monitor: one queued expectation is due just after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e, "vec");
         end
      end
   end

   // Watchdog so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      exp_t zero;
      int   wait_cycles;
      zero       = '0;
      rst        = 1'b1;
      tick_run   = 1'b0;
      tick_adj   = 1'b0;
      mode       = 2'b00;
      count_down = 1'b0;
      clear      = 1'b0;
      lap_req    = 1'b0;

      @(negedge clk);
      #1;
      checkOutput(zero, "reset");
      rst = 1'b0;

      // Build 12:34 through the adjust modes.
      for (int i = 1; i <= 12; i++)
         applyStimulus(0, 1, 2'b01, 0, 0, 0, i, 0, 0, 0);
      for (int i = 1; i <= 26; i++)
         applyStimulus(0, 1, 2'b10, 1, 0, 0, 12, 60 - i, 0, 0);
      applyStimulus(0, 0, 2'b00, 0, 0, 0, 12, 34, 0, 0);

      // Asynchronous reset pulse between edges.
      @(negedge clk);
      #1 rst = 1'b1;
      #1 checkOutput(zero, "async_rst");
      #1 rst = 1'b0;

      // Preload 59:58, then count up through the wrap.
      applyStimulus(0, 1, 2'b01, 1, 0, 0, 59, 0, 0, 0);
      applyStimulus(0, 1, 2'b10, 1, 0, 0, 59, 59, 0, 0);
      applyStimulus(0, 1, 2'b10, 1, 0, 0, 59, 58, 0, 0);
      applyStimulus(1, 0, 2'b00, 0, 0, 0, 59, 59, 0, 0);
      applyStimulus(1, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0);

      // Count down, reach 00:00, stay there in DONE.
      applyStimulus(0, 1, 2'b01, 0, 0, 0, 1, 0, 0, 0);
      applyStimulus(1, 0, 2'b00, 1, 0, 0, 0, 59, 0, 0);
      applyStimulus(0, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 2'b10, 0, 0, 0, 0, 1, 0, 0);
      applyStimulus(1, 0, 2'b00, 1, 0, 0, 0, 0, 0, 1);
      applyStimulus(1, 0, 2'b00, 1, 0, 0, 0, 0, 0, 1);
      applyStimulus(1, 0, 2'b11, 1, 0, 0, 0, 0, 0, 1);
      applyStimulus(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);

      // Adjust leaves DONE; a run strobe in adjust mode does nothing.
      applyStimulus(0, 1, 2'b01, 0, 0, 0, 1, 0, 0, 0);
      applyStimulus(1, 0, 2'b01, 0, 0, 0, 1, 0, 0, 0);

      // Seconds adjust wraps without carrying; clear wins over a tick.
      for (int i = 2; i <= 5; i++)
         applyStimulus(0, 1, 2'b01, 0, 0, 0, i, 0, 0, 0);
      applyStimulus(0, 1, 2'b10, 1, 0, 0, 5, 59, 0, 0);
      applyStimulus(0, 1, 2'b10, 0, 0, 0, 5, 0, 0, 0);
      applyStimulus(0, 1, 2'b10, 1, 0, 0, 5, 59, 0, 0);
      applyStimulus(1, 0, 2'b10, 0, 0, 0, 5, 59, 0, 0);
      applyStimulus(0, 1, 2'b10, 0, 1, 0, 0, 0, 0, 0);

      // Lap capture at 03:10 with a simultaneous run tick.
      for (int i = 1; i <= 3; i++)
         applyStimulus(0, 1, 2'b01, 0, 0, 0, i, 0, 0, 0);
      for (int i = 1; i <= 10; i++)
         applyStimulus(0, 1, 2'b10, 0, 0, 0, 3, i, 0, 0);
`ifdef LAP_CAPTURE_EN
      exp_lap_v = 1'b1;
      exp_lap_m = 6'd3;
      exp_lap_s = 6'd10;
`endif
      applyStimulus(1, 0, 2'b00, 0, 0, 1, 3, 11, 0, 0);
      applyStimulus(1, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0);
`ifdef LAP_CAPTURE_EN
      exp_lap_m = 6'd0;
      exp_lap_s = 6'd0;
`endif
      applyStimulus(0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);

      // Drain the scoreboard with a bounded wait.
      wait_cycles = 0;
      while (sb.size() > 0 && wait_cycles < 20) begin
         @(posedge clk);
         wait_cycles++;
      end
      #2;
      if (sb.size() > 0) begin
         n_checks++;
         n_fails++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
